// File: rtl/c7bicu_refill.sv
// Instruction-cache line-refill controller.
// Issues one BIU read per IFU miss, gathers four 64-bit beats into a
// 256-bit line buffer, forwards the critical doubleword to the IFU as soon
// as it lands, and strobes the finished line and tag into the cache arrays.
`timescale 1ns/1ps

module c7bicu_refill (
  input  logic         clk,
  input  logic         reset,
  input  logic         ifu_icu_miss_req,
  input  logic [31:3]  ifu_icu_miss_addr,
  input  logic         ifu_icu_miss_single,
  input  logic         ifu_icu_flush,
  output logic         icu_ifu_busy,
  output logic         icu_ifu_fwd_valid,
  output logic [63:0]  icu_ifu_fwd_data,
  output logic         icu_ifu_fwd_fault,
  output logic         icu_biu_req,
  output logic [31:3]  icu_biu_addr,
  output logic         icu_biu_single,
  input  logic         biu_icu_ack,
  input  logic         biu_icu_data_valid,
  input  logic         biu_icu_data_last,
  input  logic [63:0]  biu_icu_data,
  input  logic         biu_icu_fault,
  output logic         icu_tag_wr,
  output logic [31:5]  icu_line_addr,
  output logic [255:0] icu_line_data
);

  // Fixed line geometry: 4 beats x 64 bits.
  localparam int          LINE_BEATS = 4;
  localparam logic [2:0]  LAST_SLOT  = 3'(LINE_BEATS - 1);
  localparam logic [2:0]  FULL_CNT   = 3'(LINE_BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    CMPL = 2'd3
  } state_t;

  state_t      state;
  logic        single_q;
  logic [1:0]  crit_q;
  logic [2:0]  beat_cnt;
  logic        fault_q;
  logic        fwd_done;
  logic        flush_q;

  // Per-beat decode of the incoming BIU data.
  logic [1:0]  slot;
  logic        is_crit;
  logic        excess;
  logic        proto_err;
  logic        fault_next;
  logic        beat_done;

  // Classify the current beat: target slot, criticality and protocol errors.
  // NOTE: combinational helpers use blocking '=' with a default for every
  // signal first, so no latch is inferred; sequential state uses '<=' only.
  always_comb begin
    slot       = single_q ? crit_q : beat_cnt[1:0];
    is_crit    = single_q | (beat_cnt == {1'b0, crit_q});
    excess     = (beat_cnt == FULL_CNT);
    proto_err  = excess | (~single_q & biu_icu_data_last & (beat_cnt != LAST_SLOT));
    fault_next = fault_q | biu_icu_fault | proto_err;
    beat_done  = single_q | biu_icu_data_last;
  end

  // Refill FSM with registered outputs and the line buffer.
  // NOTE: the line buffer is flop-based and small, so it is cleared on reset
  // to keep icu_line_data deterministic; a RAM-backed buffer would not be.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      single_q          <= 1'b0;
      crit_q            <= 2'd0;
      beat_cnt          <= 3'd0;
      fault_q           <= 1'b0;
      fwd_done          <= 1'b0;
      flush_q           <= 1'b0;
      icu_ifu_busy      <= 1'b0;
      icu_ifu_fwd_valid <= 1'b0;
      icu_ifu_fwd_data  <= 64'd0;
      icu_ifu_fwd_fault <= 1'b0;
      icu_biu_req       <= 1'b0;
      icu_biu_addr      <= '0;
      icu_biu_single    <= 1'b0;
      icu_tag_wr        <= 1'b0;
      icu_line_addr     <= '0;
      icu_line_data     <= '0;
    end else begin
      // Pulses default low every cycle.
      icu_ifu_fwd_valid <= 1'b0;
      icu_tag_wr        <= 1'b0;

      case (state)
        IDLE: begin
          if (ifu_icu_miss_req) begin
            single_q       <= ifu_icu_miss_single;
            crit_q         <= ifu_icu_miss_addr[4:3];
            beat_cnt       <= 3'd0;
            fault_q        <= 1'b0;
            fwd_done       <= 1'b0;
            flush_q        <= 1'b0;
            icu_ifu_busy   <= 1'b1;
            icu_biu_req    <= 1'b1;
            icu_biu_addr   <= ifu_icu_miss_single ? ifu_icu_miss_addr
                                                  : {ifu_icu_miss_addr[31:5], 2'b00};
            icu_biu_single <= ifu_icu_miss_single;
            icu_line_addr  <= ifu_icu_miss_addr[31:5];
            state          <= REQ;
          end
        end

        REQ: begin
          if (ifu_icu_flush) flush_q <= 1'b1;
          if (biu_icu_ack) begin
            icu_biu_req <= 1'b0;
            state       <= FILL;
          end
        end

        FILL: begin
          if (ifu_icu_flush) flush_q <= 1'b1;
          if (biu_icu_data_valid) begin
            // Beats beyond a full line are dropped; only the fault sticks.
            if (!excess) begin
              icu_line_data[{slot, 6'd0} +: 64] <= biu_icu_data;
              beat_cnt <= beat_cnt + 3'd1;
            end
            fault_q <= fault_next;
            if (is_crit && !fwd_done && !excess) begin
              fwd_done <= 1'b1;
              if (!(flush_q || ifu_icu_flush)) begin
                icu_ifu_fwd_valid <= 1'b1;
                icu_ifu_fwd_data  <= biu_icu_data;
                icu_ifu_fwd_fault <= biu_icu_fault;
              end
            end
            if (beat_done) begin
              icu_tag_wr <= ~single_q & ~fault_next;
              state      <= CMPL;
            end
          end
        end

        CMPL: begin
          icu_ifu_busy <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c7bicu_refill.sv
// Directed self-checking bench for the c7bicu_refill line-refill controller.
`timescale 1ns/1ps

module tb_c7bicu_refill;

  logic         clk = 1'b0;
  logic         reset;
  logic         ifu_icu_miss_req;
  logic [31:3]  ifu_icu_miss_addr;
  logic         ifu_icu_miss_single;
  logic         ifu_icu_flush;
  logic         icu_ifu_busy;
  logic         icu_ifu_fwd_valid;
  logic [63:0]  icu_ifu_fwd_data;
  logic         icu_ifu_fwd_fault;
  logic         icu_biu_req;
  logic [31:3]  icu_biu_addr;
  logic         icu_biu_single;
  logic         biu_icu_ack;
  logic         biu_icu_data_valid;
  logic         biu_icu_data_last;
  logic [63:0]  biu_icu_data;
  logic         biu_icu_fault;
  logic         icu_tag_wr;
  logic [31:5]  icu_line_addr;
  logic [255:0] icu_line_data;

  int n_tests = 0;
  int n_fail  = 0;

  c7bicu_refill dut (
    .clk                 (clk),
    .reset               (reset),
    .ifu_icu_miss_req    (ifu_icu_miss_req),
    .ifu_icu_miss_addr   (ifu_icu_miss_addr),
    .ifu_icu_miss_single (ifu_icu_miss_single),
    .ifu_icu_flush       (ifu_icu_flush),
    .icu_ifu_busy        (icu_ifu_busy),
    .icu_ifu_fwd_valid   (icu_ifu_fwd_valid),
    .icu_ifu_fwd_data    (icu_ifu_fwd_data),
    .icu_ifu_fwd_fault   (icu_ifu_fwd_fault),
    .icu_biu_req         (icu_biu_req),
    .icu_biu_addr        (icu_biu_addr),
    .icu_biu_single      (icu_biu_single),
    .biu_icu_ack         (biu_icu_ack),
    .biu_icu_data_valid  (biu_icu_data_valid),
    .biu_icu_data_last   (biu_icu_data_last),
    .biu_icu_data        (biu_icu_data),
    .biu_icu_fault       (biu_icu_fault),
    .icu_tag_wr          (icu_tag_wr),
    .icu_line_addr       (icu_line_addr),
    .icu_line_data       (icu_line_data)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a miss for one edge.
  task automatic miss(input logic [31:0] byte_addr, input logic single);
    ifu_icu_miss_req    = 1'b1;
    ifu_icu_miss_addr   = byte_addr[31:3];
    ifu_icu_miss_single = single;
    tick();
    ifu_icu_miss_req    = 1'b0;
    ifu_icu_miss_single = 1'b0;
  endtask

  // Ack in the current REQ cycle.
  task automatic ack();
    biu_icu_ack = 1'b1;
    tick();
    biu_icu_ack = 1'b0;
  endtask

  // Deliver one beat across one edge.
  task automatic beat(input logic [63:0] data, input logic last, input logic fault);
    biu_icu_data_valid = 1'b1;
    biu_icu_data       = data;
    biu_icu_data_last  = last;
    biu_icu_fault      = fault;
    tick();
    biu_icu_data_valid = 1'b0;
    biu_icu_data_last  = 1'b0;
    biu_icu_fault      = 1'b0;
  endtask

  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CD00;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_4401;
  localparam logic [63:0] D2 = 64'h5555_6666_7777_8802;
  localparam logic [63:0] D3 = 64'h9999_AAAA_BBBB_CC03;
  localparam logic [63:0] SB = 64'hDEAD_BEEF_0000_0001;

  initial begin
    reset               = 1'b1;
    ifu_icu_miss_req    = 1'b0;
    ifu_icu_miss_addr   = '0;
    ifu_icu_miss_single = 1'b0;
    ifu_icu_flush       = 1'b0;
    biu_icu_ack         = 1'b0;
    biu_icu_data_valid  = 1'b0;
    biu_icu_data_last   = 1'b0;
    biu_icu_data        = '0;
    biu_icu_fault       = 1'b0;

    // ---- Reset state
    tick();
    tick();
    check("rst_busy",  icu_ifu_busy, 0);
    check("rst_req",   icu_biu_req, 0);
    check("rst_tagwr", icu_tag_wr, 0);
    check("rst_fwd",   icu_ifu_fwd_valid, 0);
    check("rst_line",  icu_line_data, 0);
    reset = 1'b0;
    tick();

    // ---- Line refill, crit = 2
    miss(32'h1000_0010, 1'b0);
    check("l_req",    icu_biu_req, 1);
    check("l_busy",   icu_ifu_busy, 1);
    check("l_addr",   icu_biu_addr, 29'h0200_0000);
    check("l_single", icu_biu_single, 0);
    ack();
    check("l_req_drop", icu_biu_req, 0);
    beat(D0, 1'b0, 1'b0);
    check("l_nofwd0", icu_ifu_fwd_valid, 0);
    beat(D1, 1'b0, 1'b0);
    check("l_nofwd1", icu_ifu_fwd_valid, 0);
    beat(D2, 1'b0, 1'b0);
    check("l_fwd",       icu_ifu_fwd_valid, 1);
    check("l_fwd_data",  icu_ifu_fwd_data, D2);
    check("l_fwd_fault", icu_ifu_fwd_fault, 0);
    beat(D3, 1'b1, 1'b0);
    check("l_fwd_end",  icu_ifu_fwd_valid, 0);
    check("l_tagwr",    icu_tag_wr, 1);
    check("l_lineaddr", icu_line_addr, 27'h080_0000);
    check("l_linedata", icu_line_data, {D3, D2, D1, D0});
    check("l_busy_cmpl", icu_ifu_busy, 1);
    tick();
    check("l_tagwr_end", icu_tag_wr, 0);
    check("l_busy_end",  icu_ifu_busy, 0);

    // ---- Single fetch, crit slot 1
    miss(32'h2000_0008, 1'b1);
    check("s_single", icu_biu_single, 1);
    check("s_addr",   icu_biu_addr, 29'h0400_0001);
    ack();
    beat(SB, 1'b1, 1'b0);
    check("s_fwd",      icu_ifu_fwd_valid, 1);
    check("s_fwd_data", icu_ifu_fwd_data, SB);
    check("s_tagwr",    icu_tag_wr, 0);
    check("s_slot",     icu_line_data, {D3, D2, SB, D0});
    tick();
    check("s_tagwr2", icu_tag_wr, 0);
    check("s_busy",   icu_ifu_busy, 0);

    // ---- Ack delayed 5 cycles, crit = 0
    miss(32'h3000_0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("d_req_held",  icu_biu_req, 1);
      check("d_addr_held", icu_biu_addr, 29'h0600_0000);
      tick();
    end
    check("d_req_6th", icu_biu_req, 1);
    ack();
    check("d_req_drop", icu_biu_req, 0);
    beat(D1, 1'b0, 1'b0);
    check("d_fwd",      icu_ifu_fwd_valid, 1);
    check("d_fwd_data", icu_ifu_fwd_data, D1);
    beat(D2, 1'b0, 1'b0);
    beat(D3, 1'b0, 1'b0);
    beat(D0, 1'b1, 1'b0);
    check("d_tagwr", icu_tag_wr, 1);
    check("d_line",  icu_line_data, {D0, D3, D2, D1});
    tick();

    // ---- Flush in FILL before crit beat (crit = 3)
    miss(32'h4000_0018, 1'b0);
    ack();
    beat(D0, 1'b0, 1'b0);
    ifu_icu_flush = 1'b1;
    tick();
    ifu_icu_flush = 1'b0;
    beat(D1, 1'b0, 1'b0);
    beat(D2, 1'b0, 1'b0);
    check("f_nofwd_pre", icu_ifu_fwd_valid, 0);
    beat(D3, 1'b1, 1'b0);
    check("f_nofwd", icu_ifu_fwd_valid, 0);
    check("f_tagwr", icu_tag_wr, 1);
    check("f_line",  icu_line_data, {D3, D2, D1, D0});
    tick();

    // ---- Bus fault on critical beat 1
    miss(32'h5000_0008, 1'b0);
    ack();
    beat(D0, 1'b0, 1'b0);
    beat(D1, 1'b0, 1'b1);
    check("e_fwd",       icu_ifu_fwd_valid, 1);
    check("e_fwd_data",  icu_ifu_fwd_data, D1);
    check("e_fwd_fault", icu_ifu_fwd_fault, 1);
    beat(D2, 1'b0, 1'b0);
    beat(D3, 1'b1, 1'b0);
    check("e_tagwr", icu_tag_wr, 0);
    tick();

    // ---- Early last on beat 2 (crit = 0)
    miss(32'h6000_0000, 1'b0);
    ack();
    beat(D2, 1'b0, 1'b0);
    check("p_fwd",       icu_ifu_fwd_valid, 1);
    check("p_fwd_fault", icu_ifu_fwd_fault, 0);
    beat(D1, 1'b0, 1'b0);
    beat(D0, 1'b1, 1'b0);
    check("p_tagwr",     icu_tag_wr, 0);
    check("p_busy_cmpl", icu_ifu_busy, 1);
    tick();
    check("p_busy_end", icu_ifu_busy, 0);

    // ---- Reset mid-FILL after two beats (crit = 2)
    miss(32'h7000_0010, 1'b0);
    ack();
    beat(D0, 1'b0, 1'b0);
    beat(D1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check("r_busy", icu_ifu_busy, 0);
    check("r_req",  icu_biu_req, 0);
    check("r_line", icu_line_data, 0);
    reset = 1'b0;
    beat(D2, 1'b0, 1'b0);
    check("r_trail_fwd", icu_ifu_fwd_valid, 0);
    beat(D3, 1'b1, 1'b0);
    check("r_trail_tag",  icu_tag_wr, 0);
    check("r_trail_busy", icu_ifu_busy, 0);
    tick();
    miss(32'h1000_0010, 1'b0);
    check("r2_addr", icu_biu_addr, 29'h0200_0000);
    ack();
    beat(D3, 1'b0, 1'b0);
    beat(D2, 1'b0, 1'b0);
    beat(D1, 1'b0, 1'b0);
    check("r2_fwd",      icu_ifu_fwd_valid, 1);
    check("r2_fwd_data", icu_ifu_fwd_data, D1);
    beat(D0, 1'b1, 1'b0);
    check("r2_tagwr", icu_tag_wr, 1);
    check("r2_line",  icu_line_data, {D0, D1, D2, D3});
    tick();
    check("r2_busy", icu_ifu_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/c7bicu_refill.md
# c7bicu_refill

Instruction-cache line-refill controller. It sits directly upstream of the bus interface unit on the ICU port. On an IFU miss it issues one read request to the BIU and collects the returned 64-bit beats into a 256-bit line buffer. It forwards the critical doubleword to the IFU as soon as it arrives, then writes the completed line and tag into the cache arrays in a single cycle.

## Interface
Parameters:
- LINE_BEATS, 4, beats per line (fixed 4 × 64 bit = 32-byte line; not overridable).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ifu_icu_miss_req  in  1  miss request; sampled only when icu_ifu_busy=0.
- ifu_icu_miss_addr  in  [31:3]  doubleword address of the missing fetch.
- ifu_icu_miss_single  in  1  uncacheable fetch; one beat, no array write.
- ifu_icu_flush  in  1  pipeline flush; suppresses any still-pending forward of the current refill.
- icu_ifu_busy  out  1  refill in progress; IFU must not issue a miss.
- icu_ifu_fwd_valid  out  1  one-cycle pulse carrying the critical doubleword.
- icu_ifu_fwd_data  out  [63:0]  critical doubleword.
- icu_ifu_fwd_fault  out  1  forwarded beat carried a bus fault.
- icu_biu_req  out  1  read request to BIU; held until acked.
- icu_biu_addr  out  [31:3]  request address.
- icu_biu_single  out  1  single-beat request.
- biu_icu_ack  in  1  request accepted.
- biu_icu_data_valid  in  1  read beat valid.
- biu_icu_data_last  in  1  final beat of burst.
- biu_icu_data  in  [63:0]  read beat.
- biu_icu_fault  in  1  bus error on this beat.
- icu_tag_wr  out  1  one-cycle line/tag write strobe.
- icu_line_addr  out  [31:5]  line address for tag/data write.
- icu_line_data  out  [255:0]  completed line; beat k occupies bits [64k+63:64k].

## Operation
States: IDLE, REQ, FILL, CMPL.

- IDLE:
  - icu_ifu_busy=0.
  - On ifu_icu_miss_req, latch addr, single and crit = addr[4:3]; clear beat_cnt, fault_q, fwd_done, flush_q; go to REQ.
- REQ:
  - icu_biu_req=1.
  - icu_biu_addr = single ? latched addr : {addr[31:5],2'b00}.
  - icu_biu_single = single.
  - Stay until biu_icu_ack=1 (ack may arrive in the first REQ cycle); then go to FILL.
- FILL, on each biu_icu_data_valid:
  - Write biu_icu_data into line slot beat_cnt[1:0] (slot crit when single).
  - beat_cnt increments, 3-bit, saturating at 4.
  - fault_q |= biu_icu_fault.
  - If the beat is the critical one (beat_cnt==crit, or single) and fwd_done=0, raise a forward next cycle unless flush_q or ifu_icu_flush is set. Set fwd_done either way.
  - On biu_icu_data_last (or the first beat when single), go to CMPL.
- Protocol error: last arriving with beat_cnt≠3 on a line refill, or a 5th beat, sets fault_q. Excess beats are dropped.
- CMPL (one cycle):
  - icu_tag_wr = ~single & ~fault_q.
  - Return to IDLE.
- ifu_icu_flush in REQ or FILL sets flush_q. The refill still completes and the line is still written; only the forward is suppressed. Flush in IDLE or CMPL has no effect.
- Beats arriving in IDLE, REQ or CMPL are ignored.

## Timing
- Reset values: all outputs 0, state IDLE, line buffer 0.
- Reset mid-refill: returns to IDLE immediately; outstanding BIU beats after reset are ignored.
- Miss accepted at edge T: icu_biu_req=1 and icu_ifu_busy=1 from T+1.
- icu_biu_req drops the cycle after ack.
- Critical beat valid at edge T: icu_ifu_fwd_valid is a registered pulse at T+1 with data and fault.
- Last beat at edge T: CMPL at T+1 with icu_tag_wr, icu_line_addr and icu_line_data stable; busy drops at T+2.
- A new miss can be accepted at T+2.
- A forward and the CMPL tag write may coincide (critical beat = last beat).
- Minimum miss-to-CMPL latency with zero-wait BIU: 6 cycles for a line, 3 for single.

## Test plan
- Line refill, miss_addr=0x1000_0010 (crit=2), beats D0..D3 back-to-back:
  - icu_biu_addr=0x1000_0000>>3, single=0.
  - fwd pulse with D2 one cycle after beat 2.
  - CMPL: tag_wr=1, line_addr=0x1000_0000>>5, line_data={D3,D2,D1,D0}.
- Single fetch, addr 0x2000_0008, one beat 0xDEAD_BEEF_0000_0001 with last:
  - icu_biu_single=1, addr unmodified.
  - fwd_data equals the beat.
  - tag_wr never asserts.
- Ack delayed 5 cycles: req held constant for all 6 REQ cycles, then drops.
- Flush asserted in FILL before critical beat (crit=3): no fwd_valid; tag_wr=1 with the full line.
- biu_icu_fault on beat 1, and separately last on beat 2: tag_wr=0; fwd_fault=1 if the faulting beat is critical.
- Reset asserted in FILL after 2 beats: outputs 0 next cycle; trailing beats produce no fwd or tag_wr; the next miss refills normally.
